// File: rtl/m68k_assoc_cache_controller.sv
// 2-way set-associative write-through cache controller between a TG68 bus and an SDRAM controller.
// Define WRITE_HIT_UPDATE_EN to update cached data on write hits; otherwise a write hit invalidates the line.
module m68k_assoc_cache_controller #(
    parameter int INDEX_BITS      = 5,
    parameter int LINE_WORDS_LOG2 = 3,
    localparam int OFF            = LINE_WORDS_LOG2 + 1,
    localparam int TAG_W          = 32 - OFF - INDEX_BITS
) (
    input  logic                       Clock,
    input  logic                       Reset_H,
    input  logic                       Flush_H,
    input  logic                       AS_L,
    input  logic                       UDS_L,
    input  logic                       LDS_L,
    input  logic                       WE_L,
    input  logic                       DramSelect68k_H,
    input  logic [31:0]                AddressBusInFrom68k,
    input  logic [15:0]                DataBusInFrom68k,
    output logic [15:0]                DataBusOutTo68k,
    output logic                       DtackTo68k_L,
    input  logic                       DtackFromDram_L,
    input  logic                       CAS_Dram_L,
    input  logic                       RAS_Dram_L,
    input  logic [15:0]                DataBusInFromDram,
    output logic [31:0]                AddressBusOutToDramController,
    output logic                       UDS_DramController_L,
    output logic                       LDS_DramController_L,
    output logic                       WE_DramController_L,
    output logic                       DramSelectFromCache_L,
    output logic [INDEX_BITS-1:0]      Index,
    output logic [LINE_WORDS_LOG2-1:0] WordAddress,
    output logic [TAG_W-1:0]           TagDataOut,
    input  logic [2*TAG_W-1:0]         TagIn,
    input  logic [1:0]                 ValidIn,
    input  logic [31:0]                DataInFromCache,
    output logic [1:0]                 TagCache_WE_L,
    output logic [1:0]                 ValidBit_WE_L,
    output logic                       ValidBitOut_H,
    output logic [1:0]                 DataCache_WE_L,
    output logic [1:0]                 DataByteEn_H,
    output logic [15:0]                DataBusOutToCache,
    output logic [3:0]                 CacheState
);

    localparam int SETS       = 1 << INDEX_BITS;
    localparam int LINE_WORDS = 1 << LINE_WORDS_LOG2;

    typedef enum logic [3:0] {
        S_INVALIDATE = 4'd0,
        S_IDLE       = 4'd1,
        S_CHECK_HIT  = 4'd2,
        S_HIT_WAIT   = 4'd3,
        S_FILL_START = 4'd4,
        S_CAS1       = 4'd5,
        S_CAS2       = 4'd6,
        S_BURST_FILL = 4'd7,
        S_END_FILL   = 4'd8,
        S_WRITE_DRAM = 4'd9
    } state_t;

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    way_q, way_d;
    logic                    lru_q [SETS];
    logic                    lru_we, lru_val;
    logic [INDEX_BITS-1:0]   lru_idx;

    logic [TAG_W-1:0]           tag_a;
    logic [INDEX_BITS-1:0]      set_a;
    logic [LINE_WORDS_LOG2-1:0] word_a;
    logic                       hit0, hit1, hit, hit_way;

    assign tag_a   = AddressBusInFrom68k[31:OFF+INDEX_BITS];
    assign set_a   = AddressBusInFrom68k[OFF+INDEX_BITS-1:OFF];
    assign word_a  = AddressBusInFrom68k[OFF-1:1];
    assign hit0    = ValidIn[0] && (TagIn[TAG_W-1:0] == tag_a);
    assign hit1    = ValidIn[1] && (TagIn[2*TAG_W-1:TAG_W] == tag_a);
    assign hit     = hit0 || hit1;
    assign hit_way = ~hit0;

    assign CacheState = state_q;

    // way_q holds the hit way through HIT_WAIT and the victim way through a fill
    always_ff @(posedge Clock) begin
        if (Reset_H) begin
            state_q <= S_INVALIDATE;
            cnt_q   <= '0;
            way_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
            if (lru_we) lru_q[lru_idx] <= lru_val;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        way_d   = way_q;
        lru_we  = 1'b0;
        lru_idx = set_a;
        lru_val = 1'b0;

        DataBusOutTo68k               = '0;
        DtackTo68k_L                  = 1'b1;
        AddressBusOutToDramController = {AddressBusInFrom68k[31:OFF], {OFF{1'b0}}};
        UDS_DramController_L          = UDS_L;
        LDS_DramController_L          = LDS_L;
        WE_DramController_L           = WE_L;
        DramSelectFromCache_L         = 1'b1;
        Index                         = set_a;
        WordAddress                   = word_a;
        TagDataOut                    = tag_a;
        TagCache_WE_L                 = '1;
        ValidBit_WE_L                 = '1;
        ValidBitOut_H                 = 1'b0;
        DataCache_WE_L                = '1;
        DataByteEn_H                  = '0;
        DataBusOutToCache             = DataBusInFrom68k;

        if (!Reset_H) begin
            case (state_q)
                S_INVALIDATE: begin
                    Index         = cnt_q[INDEX_BITS-1:0];
                    ValidBit_WE_L = '0;
                    lru_we        = 1'b1;
                    lru_idx       = cnt_q[INDEX_BITS-1:0];
                    if (cnt_q == 16'(SETS - 1)) state_d = S_IDLE;
                end
                S_IDLE: begin
                    if (Flush_H && AS_L) begin
                        cnt_d   = '0;
                        state_d = S_INVALIDATE;
                    end else if (!AS_L && DramSelect68k_H) begin
                        if (WE_L) begin
                            state_d = S_CHECK_HIT;
                        end else if (!UDS_L || !LDS_L) begin
                            if (hit) begin
`ifdef WRITE_HIT_UPDATE_EN
                                DataCache_WE_L[hit_way] = 1'b0;
                                DataByteEn_H            = {~UDS_L, ~LDS_L};
                                lru_we                  = 1'b1;
                                lru_val                 = ~hit_way;
`else
                                ValidBit_WE_L[hit_way]  = 1'b0;
`endif
                            end
                            DramSelectFromCache_L = 1'b0;
                            state_d               = S_WRITE_DRAM;
                        end
                    end
                end
                S_WRITE_DRAM: begin
                    AddressBusOutToDramController = AddressBusInFrom68k;
                    DramSelectFromCache_L         = 1'b0;
                    DtackTo68k_L                  = DtackFromDram_L;
                    if (AS_L || !DramSelect68k_H) state_d = S_IDLE;
                end
                S_CHECK_HIT: begin
                    if (hit) begin
                        DataBusOutTo68k = hit_way ? DataInFromCache[31:16] : DataInFromCache[15:0];
                        DtackTo68k_L    = 1'b0;
                        lru_we          = 1'b1;
                        lru_val         = ~hit_way;
                        way_d           = hit_way;
                        state_d         = S_HIT_WAIT;
                    end else begin
                        way_d                 = !ValidIn[0] ? 1'b0 : (!ValidIn[1] ? 1'b1 : lru_q[set_a]);
                        DramSelectFromCache_L = 1'b0;
                        state_d               = S_FILL_START;
                    end
                end
                S_HIT_WAIT: begin
                    DataBusOutTo68k = way_q ? DataInFromCache[31:16] : DataInFromCache[15:0];
                    if (AS_L) state_d = S_IDLE;
                    else      DtackTo68k_L = 1'b0;
                end
                S_FILL_START, S_CAS1, S_CAS2, S_BURST_FILL: begin
                    DramSelectFromCache_L = 1'b0;
                    UDS_DramController_L  = 1'b0;
                    LDS_DramController_L  = 1'b0;
                    case (state_q)
                        S_FILL_START: begin
                            TagCache_WE_L[way_q] = 1'b0;
                            ValidBit_WE_L[way_q] = 1'b0;
                            ValidBitOut_H        = 1'b1;
                            // RAS low with CAS low is a refresh cycle, not our burst
                            if (!CAS_Dram_L && RAS_Dram_L) state_d = S_CAS1;
                        end
                        S_CAS1: state_d = S_CAS2;
                        S_CAS2: begin
                            cnt_d   = '0;
                            state_d = S_BURST_FILL;
                        end
                        default: begin
                            if (cnt_q < 16'(LINE_WORDS)) begin
                                WordAddress           = cnt_q[LINE_WORDS_LOG2-1:0];
                                DataCache_WE_L[way_q] = 1'b0;
                                DataByteEn_H          = 2'b11;
                                DataBusOutToCache     = DataBusInFromDram;
                            end else begin
                                lru_we  = 1'b1;
                                lru_val = ~way_q;
                                state_d = S_END_FILL;
                            end
                        end
                    endcase
                end
                S_END_FILL: begin
                    DataBusOutTo68k = way_q ? DataInFromCache[31:16] : DataInFromCache[15:0];
                    DtackTo68k_L    = 1'b0;
                    if (AS_L || !DramSelect68k_H) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_assoc_cache_controller.sv
// Scoreboard bench for m68k_assoc_cache_controller: external RAM/DRAM models plus a set/tag/LRU reference model.
// Honours WRITE_HIT_UPDATE_EN the same way the design does.
module tb_m68k_assoc_cache_controller;

    localparam int TAG_W      = 23;
    localparam int LINE_WORDS = 8;

    logic        clk = 1'b0;
    logic        Reset_H, Flush_H, AS_L, UDS_L, LDS_L, WE_L, DramSelect68k_H;
    logic [31:0] AddressBusInFrom68k;
    logic [15:0] DataBusInFrom68k, DataBusOutTo68k, DataBusInFromDram, DataBusOutToCache;
    logic        DtackTo68k_L, DtackFromDram_L, CAS_Dram_L, RAS_Dram_L;
    logic [31:0] AddressBusOutToDramController;
    logic        UDS_DramController_L, LDS_DramController_L, WE_DramController_L, DramSelectFromCache_L;
    logic [4:0]  Index;
    logic [2:0]  WordAddress;
    logic [TAG_W-1:0]   TagDataOut;
    logic [2*TAG_W-1:0] TagIn;
    logic [1:0]  ValidIn, TagCache_WE_L, ValidBit_WE_L, DataCache_WE_L, DataByteEn_H;
    logic [31:0] DataInFromCache;
    logic        ValidBitOut_H;
    logic [3:0]  CacheState;

    always #5 clk = ~clk;

    m68k_assoc_cache_controller #(.INDEX_BITS(5), .LINE_WORDS_LOG2(3)) dut (
        .Clock(clk), .Reset_H(Reset_H), .Flush_H(Flush_H), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
        .WE_L(WE_L), .DramSelect68k_H(DramSelect68k_H), .AddressBusInFrom68k(AddressBusInFrom68k),
        .DataBusInFrom68k(DataBusInFrom68k), .DataBusOutTo68k(DataBusOutTo68k), .DtackTo68k_L(DtackTo68k_L),
        .DtackFromDram_L(DtackFromDram_L), .CAS_Dram_L(CAS_Dram_L), .RAS_Dram_L(RAS_Dram_L),
        .DataBusInFromDram(DataBusInFromDram), .AddressBusOutToDramController(AddressBusOutToDramController),
        .UDS_DramController_L(UDS_DramController_L), .LDS_DramController_L(LDS_DramController_L),
        .WE_DramController_L(WE_DramController_L), .DramSelectFromCache_L(DramSelectFromCache_L),
        .Index(Index), .WordAddress(WordAddress), .TagDataOut(TagDataOut), .TagIn(TagIn), .ValidIn(ValidIn),
        .DataInFromCache(DataInFromCache), .TagCache_WE_L(TagCache_WE_L), .ValidBit_WE_L(ValidBit_WE_L),
        .ValidBitOut_H(ValidBitOut_H), .DataCache_WE_L(DataCache_WE_L), .DataByteEn_H(DataByteEn_H),
        .DataBusOutToCache(DataBusOutToCache), .CacheState(CacheState)
    );

    // External tag / valid / data RAMs for both ways
    logic [TAG_W-1:0] tag_ram [2][32];
    logic             vld_ram [2][32];
    logic [15:0]      dat_ram [2][256];

    assign TagIn           = {tag_ram[1][Index], tag_ram[0][Index]};
    assign ValidIn         = {vld_ram[1][Index], vld_ram[0][Index]};
    assign DataInFromCache = {dat_ram[1][{Index, WordAddress}], dat_ram[0][{Index, WordAddress}]};

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++) begin
            if (!TagCache_WE_L[w]) tag_ram[w][Index] <= TagDataOut;
            if (!ValidBit_WE_L[w]) vld_ram[w][Index] <= ValidBitOut_H;
            if (!DataCache_WE_L[w]) begin
                if (DataByteEn_H[1]) dat_ram[w][{Index, WordAddress}][15:8] <= DataBusOutToCache[15:8];
                if (DataByteEn_H[0]) dat_ram[w][{Index, WordAddress}][7:0]  <= DataBusOutToCache[7:0];
            end
        end
    end

    // DRAM: 4 KB window at 0x0800_0000; writes go through the DRAM-controller strobes from the 68k data bus
    function automatic logic [15:0] init_word(input int unsigned i);
        return 16'((i * 32'h9E37) ^ 32'h5A5A);
    endfunction

    logic [15:0] dram [2048];
    bit          dram_ready = 1'b0;
    logic        ras_l, cas_l;
    assign RAS_Dram_L        = ras_l;
    assign CAS_Dram_L        = cas_l;
    assign DataBusInFromDram = dram[{AddressBusOutToDramController[11:4], WordAddress}];
    assign DtackFromDram_L   = !(CacheState == 4'd9 && !DramSelectFromCache_L && !WE_DramController_L);

    always @(posedge clk) begin
        if (!dram_ready) begin
            for (int i = 0; i < 2048; i++) dram[i] <= init_word(i);
            dram_ready <= 1'b1;
        end else if (!DtackFromDram_L && AddressBusOutToDramController[31:12] == 20'h08000) begin
            if (!UDS_DramController_L) dram[AddressBusOutToDramController[11:1]][15:8] <= DataBusInFrom68k[15:8];
            if (!LDS_DramController_L) dram[AddressBusOutToDramController[11:1]][7:0]  <= DataBusInFrom68k[7:0];
        end
    end

    // Reference model: memory image plus, per set, which tags are resident and which way goes next
    logic [15:0] shadow [2048];
    bit          ref_valid [2][32];
    int unsigned ref_tag [2][32];
    bit          ref_next [32];

    typedef struct { logic [15:0] data; bit hit; bit way; } exp_t;
    exp_t sbq [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic ref_reset();
        for (int s = 0; s < 32; s++) begin
            ref_valid[0][s] = 0; ref_valid[1][s] = 0; ref_next[s] = 0;
        end
    endtask

    function automatic int ref_lookup(input logic [31:0] a);
        for (int w = 0; w < 2; w++)
            if (ref_valid[w][a[8:4]] && ref_tag[w][a[8:4]] == int'(a[31:9])) return w;
        return -1;
    endfunction

    task automatic ref_read(input logic [31:0] a, output bit hit, output bit way);
        int w;
        int unsigned s;
        s = a[8:4];
        w = ref_lookup(a);
        hit = (w >= 0);
        if (hit) way = w[0];
        else if (!ref_valid[0][s]) way = 0;
        else if (!ref_valid[1][s]) way = 1;
        else way = ref_next[s];
        ref_valid[way][s] = 1;
        ref_tag[way][s]   = a[31:9];
        ref_next[s]       = !way;
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] strb_l);
        int w;
        if (!strb_l[1]) shadow[a[11:1]][15:8] = d[15:8];
        if (!strb_l[0]) shadow[a[11:1]][7:0]  = d[7:0];
        w = ref_lookup(a);
        if (w >= 0) begin
`ifdef WRITE_HIT_UPDATE_EN
            ref_next[a[8:4]] = !w[0];
`else
            ref_valid[w][a[8:4]] = 0;
`endif
        end
    endtask

    // Monitor: pops one expectation per read transaction when the DUT first asserts DTACK
    bit done_q, fill_seen, fill_way, pulse_err;
    int pulses;
    always @(negedge clk) begin
        exp_t e;
        if (AS_L) begin
            done_q = 0; fill_seen = 0; pulses = 0; pulse_err = 0;
        end else begin
            if (CacheState == 4'd4) fill_seen = 1;
            if (CacheState == 4'd7 && DataCache_WE_L != 2'b11) begin
                fill_way = (DataCache_WE_L == 2'b01);
                if (WordAddress != pulses[2:0]) pulse_err = 1;
                pulses++;
            end
            if (!DtackTo68k_L && WE_L && !done_q) begin
                done_q = 1;
                if (sbq.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_underflow: got dtack with no pending read (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("rd_data", DataBusOutTo68k, e.data);
                    chk("rd_hit", !fill_seen, e.hit);
                    if (!e.hit) begin
                        chk("fill_way", fill_way, e.way);
                        chk("fill_pulses", pulses, LINE_WORDS);
                        chk("fill_wordaddr_seq", pulse_err, 0);
                    end
                end
            end
        end
    end

    task automatic wait_dtack(input string name);
        int n = 0;
        while (DtackTo68k_L !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL %s_timeout: dtack not seen within %0d cycles", name, n);
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        exp_t e;
        ref_read(a, e.hit, e.way);
        e.data = shadow[a[11:1]];
        sbq.push_back(e);
        @(posedge clk); #1;
        AddressBusInFrom68k = a; WE_L = 1; UDS_L = 0; LDS_L = 0; AS_L = 0;
        @(negedge clk);
        wait_dtack("rd");
        if (DtackTo68k_L !== 1'b0 && sbq.size() > 0) void'(sbq.pop_back());
        @(posedge clk); #1;
        AS_L = 1; UDS_L = 1; LDS_L = 1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] strb_l,
                            output logic [5:0] snap);
        ref_write(a, d, strb_l);
        @(posedge clk); #1;
        AddressBusInFrom68k = a; DataBusInFrom68k = d; WE_L = 0; {UDS_L, LDS_L} = strb_l; AS_L = 0;
        @(negedge clk);
        snap = {DataCache_WE_L, ValidBit_WE_L, DataByteEn_H};
        wait_dtack("wr");
        @(posedge clk); #1;
        AS_L = 1; WE_L = 1; UDS_L = 1; LDS_L = 1;
    endtask

    task automatic check_sweep(input string name);
        int bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (ValidBit_WE_L !== 2'b00 || Index !== 5'(i) || ValidBitOut_H !== 1'b0 ||
                DataCache_WE_L !== 2'b11 || TagCache_WE_L !== 2'b11) bad++;
        end
        chk({name, "_sweep"}, bad, 0);
        @(negedge clk);
        chk({name, "_idle"}, CacheState, 4'd1);
        chk({name, "_sweep_end"}, ValidBit_WE_L, 2'b11);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  snap;
        logic [31:0] a;
        int          n, stay;

        Reset_H = 1; Flush_H = 0; AS_L = 1; UDS_L = 1; LDS_L = 1; WE_L = 1; DramSelect68k_H = 1;
        AddressBusInFrom68k = '0; DataBusInFrom68k = '0; ras_l = 1; cas_l = 0;
        for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
        ref_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", CacheState, 4'd0);
        chk("rst_dtack", DtackTo68k_L, 1'b1);
        chk("rst_valid_we", ValidBit_WE_L, 2'b11);
        chk("rst_dram_sel", DramSelectFromCache_L, 1'b1);
        @(posedge clk); #1 Reset_H = 0;
        check_sweep("reset");

        do_read(32'h0800_0010);
        do_read(32'h0800_0012);
        do_read(32'h0800_0212);
        do_read(32'h0800_0412);

        do_write(32'h0800_0212, 16'h1234, 2'b01, snap);
`ifdef WRITE_HIT_UPDATE_EN
        chk("wh_data_we", snap[5:4], 2'b01);
        chk("wh_byte_en", snap[1:0], 2'b10);
`else
        chk("wh_valid_we", snap[3:2], 2'b01);
        chk("wh_no_data_we", snap[5:4], 2'b11);
`endif
        do_read(32'h0800_0212);

        ras_l = 0;
        fork
            do_read(32'h0800_0620);
            begin
                n = 0;
                while (CacheState !== 4'd4 && n < 100) begin @(negedge clk); n++; end
                stay = 0;
                repeat (4) begin @(negedge clk); if (CacheState == 4'd4) stay++; end
                chk("refresh_hold", stay, 4);
                @(posedge clk); #1 ras_l = 1;
                @(posedge clk);
                @(negedge clk);
                chk("refresh_to_cas1", CacheState, 4'd5);
            end
        join

        @(posedge clk); #1 Flush_H = 1;
        @(posedge clk); #1 Flush_H = 0;
        ref_reset();
        check_sweep("flush");
        do_read(32'h0800_0010);

        for (int t = 0; t < 150; t++) begin
            a = 32'h0800_0000 | ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 7) << 1);
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       do_write(a, 16'($urandom), 2'b01, snap);
                    1:       do_write(a, 16'($urandom), 2'b10, snap);
                    default: do_write(a, 16'($urandom), 2'b00, snap);
                endcase
            end else begin
                do_read(a);
            end
        end

        // Reset in the middle of a burst fill
        @(posedge clk); #1;
        AddressBusInFrom68k = 32'h0800_0A50; WE_L = 1; UDS_L = 0; LDS_L = 0; AS_L = 0;
        n = 0;
        @(negedge clk);
        while (!(CacheState == 4'd7 && DataCache_WE_L != 2'b11 && WordAddress == 3'd3) && n < 100) begin
            @(negedge clk); n++;
        end
        chk("burst_word3_reached", n < 100, 1'b1);
        Reset_H = 1;
        @(negedge clk);
        chk("midrst_state", CacheState, 4'd0);
        chk("midrst_data_we", DataCache_WE_L, 2'b11);
        chk("midrst_tag_we", TagCache_WE_L, 2'b11);
        chk("midrst_valid_we", ValidBit_WE_L, 2'b11);
        @(posedge clk); #1 AS_L = 1; UDS_L = 1; LDS_L = 1;
        @(posedge clk); #1 Reset_H = 0;
        ref_reset();
        check_sweep("midrst");
        do_read(32'h0800_0A50);
        do_read(32'h0800_0A52);

        repeat (5) @(posedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
